rx_block_lock: RTL and testbench

//  64b/66b block-lock FSM (IEEE 802.3 cl.49 lock_fsm) on the PCS Rx path, after the Rx gearbox and

---
 rtl/rx_block_lock.sv | 143 ++++++++++++++
 tb/tb_rx_block_lock.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_lock.sv
// 64b/66b block-lock controller: hunts for sync-header alignment by slipping the Rx gearbox,
// then holds lock until too many bad headers land in one header window.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// ST_HUNT      | searching; counting consecutive good headers toward lock
// ST_LOCKED    | block lock held; counting bad headers per window
// ST_SLIP_WAIT | slip issued; ignoring headers while the gearbox realigns
module rx_block_lock #(
   parameter int SH_CNT_MAX       = 64,
   parameter int SH_INVALID_MAX   = 16,
   parameter int SLIP_WAIT_BLOCKS = 4
) (
   input  logic        i_rxc,
   input  logic        i_reset_n,
   input  logic        i_init_done,
   input  logic [1:0]  i_rx_header,
   input  logic        i_rx_data_valid,
   input  logic        i_rx_header_valid,
   output logic        o_slip,
   output logic        o_block_lock,
   output logic        o_rx_header_valid,
   output logic [15:0] o_slip_count
);

   localparam int SW_W = (SLIP_WAIT_BLOCKS > 1) ? $clog2(SLIP_WAIT_BLOCKS) : 1;
   localparam logic [6:0]      CNT_LAST  = 7'(SH_CNT_MAX - 1);
   localparam logic [4:0]      INV_LIMIT = 5'(SH_INVALID_MAX);
   localparam logic [SW_W-1:0] SW_LOAD   = SW_W'(SLIP_WAIT_BLOCKS - 1);

   typedef enum logic [1:0] {
      ST_HUNT      = 2'd0,
      ST_LOCKED    = 2'd1,
      ST_SLIP_WAIT = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [6:0]      sh_cnt, sh_cnt_nxt;
   logic [4:0]      sh_inv, sh_inv_nxt, sh_inv_sum;
   logic [SW_W-1:0] sw_cnt, sw_cnt_nxt;
   logic            slip_nxt;
   logic            slip_q;
   logic            lock_q;
   logic [15:0]     slip_cnt_q;
   logic            ev;
   logic            sh_ok;

   assign ev         = i_rx_data_valid & i_rx_header_valid;
   assign sh_ok      = i_rx_header[1] ^ i_rx_header[0];
   assign sh_inv_sum = sh_inv + {4'd0, ~sh_ok};

   always_ff @(posedge i_rxc or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= ST_HUNT;
         sh_cnt     <= '0;
         sh_inv     <= '0;
         sw_cnt     <= '0;
         slip_q     <= 1'b0;
         lock_q     <= 1'b0;
         slip_cnt_q <= '0;
      end else begin
         state  <= state_nxt;
         sh_cnt <= sh_cnt_nxt;
         sh_inv <= sh_inv_nxt;
         sw_cnt <= sw_cnt_nxt;
         slip_q <= slip_nxt;
         lock_q <= (state_nxt == ST_LOCKED);
         if (slip_nxt && (slip_cnt_q != 16'hFFFF)) begin
            slip_cnt_q <= slip_cnt_q + 16'd1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      sh_cnt_nxt = sh_cnt;
      sh_inv_nxt = sh_inv;
      sw_cnt_nxt = sw_cnt;
      slip_nxt   = 1'b0;

      if (!i_init_done) begin
         state_nxt  = ST_HUNT;
         sh_cnt_nxt = '0;
         sh_inv_nxt = '0;
         sw_cnt_nxt = '0;
      end else if (ev) begin
         unique case (state)
            ST_HUNT: begin
               if (!sh_ok) begin
                  state_nxt  = ST_SLIP_WAIT;
                  slip_nxt   = 1'b1;
                  sh_cnt_nxt = '0;
                  sh_inv_nxt = '0;
                  sw_cnt_nxt = SW_LOAD;
               end else if (sh_cnt == CNT_LAST) begin
                  state_nxt  = ST_LOCKED;
                  sh_cnt_nxt = '0;
                  sh_inv_nxt = '0;
               end else begin
                  sh_cnt_nxt = sh_cnt + 7'd1;
               end
            end
            ST_LOCKED: begin
               // Loss of lock is checked before the window-end clear.
               if (sh_inv_sum == INV_LIMIT) begin
                  state_nxt  = ST_SLIP_WAIT;
                  slip_nxt   = 1'b1;
                  sh_cnt_nxt = '0;
                  sh_inv_nxt = '0;
                  sw_cnt_nxt = SW_LOAD;
               end else if (sh_cnt == CNT_LAST) begin
                  sh_cnt_nxt = '0;
                  sh_inv_nxt = '0;
               end else begin
                  sh_cnt_nxt = sh_cnt + 7'd1;
                  sh_inv_nxt = sh_inv_sum;
               end
            end
            ST_SLIP_WAIT: begin
               if (sw_cnt == '0) begin
                  state_nxt  = ST_HUNT;
                  sh_cnt_nxt = '0;
                  sh_inv_nxt = '0;
               end else begin
                  sw_cnt_nxt = sw_cnt - SW_W'(1);
               end
            end
            default: begin
               state_nxt  = ST_HUNT;
               sh_cnt_nxt = '0;
               sh_inv_nxt = '0;
               sw_cnt_nxt = '0;
            end
         endcase
      end
   end

   assign o_slip            = slip_q;
   assign o_block_lock      = lock_q;
   assign o_slip_count      = slip_cnt_q;
   assign o_rx_header_valid = i_rx_header_valid & i_rx_data_valid & lock_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock: a window-counting reference model checked every cycle,
// plus literal expectations at the points where lock, slip and the status count must change.
module tb_rx_block_lock;

   logic        i_rxc = 1'b0;
   logic        i_reset_n;
   logic        i_init_done;
   logic [1:0]  i_rx_header;
   logic        i_rx_data_valid;
   logic        i_rx_header_valid;
   logic        o_slip;
   logic        o_block_lock;
   logic        o_rx_header_valid;
   logic [15:0] o_slip_count;

   rx_block_lock dut (
      .i_rxc             (i_rxc),
      .i_reset_n         (i_reset_n),
      .i_init_done       (i_init_done),
      .i_rx_header       (i_rx_header),
      .i_rx_data_valid   (i_rx_data_valid),
      .i_rx_header_valid (i_rx_header_valid),
      .o_slip            (o_slip),
      .o_block_lock      (o_block_lock),
      .o_rx_header_valid (o_rx_header_valid),
      .o_slip_count      (o_slip_count)
   );

   always #5 i_rxc = ~i_rxc;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: window position, bad-header tally and wait tally as plain numbers.
   localparam logic [1:0] M_HUNT = 2'd0;
   localparam logic [1:0] M_LOCK = 2'd1;
   localparam logic [1:0] M_WAIT = 2'd2;

   typedef struct packed {
      logic [1:0]  mode;
      logic [6:0]  seen;
      logic [4:0]  nbad;
      logic [2:0]  waited;
      logic        slip;
      logic [15:0] slips;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t step(mdl_t cur, logic init, logic ev, logic [1:0] h);
      mdl_t r;
      logic ok;
      int   nb;
      r      = cur;
      r.slip = 1'b0;
      ok     = (h == 2'b01) || (h == 2'b10);
      nb     = int'(cur.nbad) + (ok ? 0 : 1);
      if (!init) begin
         r.mode = M_HUNT; r.seen = '0; r.nbad = '0; r.waited = '0;
      end else if (ev) begin
         if (cur.mode == M_HUNT) begin
            if (!ok) begin
               r.mode = M_WAIT; r.seen = '0; r.nbad = '0; r.waited = '0; r.slip = 1'b1;
            end else if (int'(cur.seen) + 1 == 64) begin
               r.mode = M_LOCK; r.seen = '0; r.nbad = '0;
            end else begin
               r.seen = cur.seen + 7'd1;
            end
         end else if (cur.mode == M_LOCK) begin
            if (nb == 16) begin
               r.mode = M_WAIT; r.seen = '0; r.nbad = '0; r.waited = '0; r.slip = 1'b1;
            end else if (int'(cur.seen) + 1 == 64) begin
               r.seen = '0; r.nbad = '0;
            end else begin
               r.seen = cur.seen + 7'd1;
               r.nbad = 5'(nb);
            end
         end else begin
            if (int'(cur.waited) + 1 == 4) begin
               r.mode = M_HUNT; r.waited = '0;
            end else begin
               r.waited = cur.waited + 3'd1;
            end
         end
      end
      if (r.slip && (cur.slips != 16'hFFFF)) r.slips = cur.slips + 16'd1;
      return r;
   endfunction

   always @(posedge i_rxc or negedge i_reset_n) begin
      if (!i_reset_n) m <= '0;
      else m <= step(m, i_init_done, i_rx_data_valid & i_rx_header_valid, i_rx_header);
   end

   always @(negedge i_rxc) begin
      chk("cyc_block_lock", 32'(o_block_lock), 32'(m.mode == M_LOCK));
      chk("cyc_slip",       32'(o_slip),       32'(m.slip));
      chk("cyc_slip_count", 32'(o_slip_count), 32'(m.slips));
      chk("cyc_hdr_valid",  32'(o_rx_header_valid),
          32'(i_rx_header_valid & i_rx_data_valid & (m.mode == M_LOCK)));
   end

   task automatic beat(input logic dv, input logic hv, input logic [1:0] h);
      i_rx_data_valid   = dv;
      i_rx_header_valid = hv;
      i_rx_header       = h;
      @(posedge i_rxc);
      #1;
   endtask

   task automatic ev1(input logic [1:0] h);
      beat(1'b1, 1'b1, h);
   endtask

   task automatic half();
      beat(1'b1, 1'b0, 2'b11);
   endtask

   task automatic good_evs(input int n);
      for (int i = 0; i < n; i++) begin
         ev1((i % 2 == 0) ? 2'b01 : 2'b10);
         half();
      end
   endtask

   task automatic ignored_evs();
      for (int i = 0; i < 4; i++) begin
         ev1(2'b11);
         half();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset_n         = 1'b0;
      i_init_done       = 1'b0;
      i_rx_header       = 2'b00;
      i_rx_data_valid   = 1'b0;
      i_rx_header_valid = 1'b0;
      #22;
      chk("rst_lock",  32'(o_block_lock), 32'd0);
      chk("rst_slip",  32'(o_slip),       32'd0);
      chk("rst_count", 32'(o_slip_count), 32'd0);
      i_reset_n   = 1'b1;
      i_init_done = 1'b1;
      beat(1'b0, 1'b0, 2'b00);

      // 1: 64 good headers, lock the cycle after the 64th
      good_evs(63);
      chk("t1_lock_before", 32'(o_block_lock), 32'd0);
      ev1(2'b10);
      chk("t1_lock_after", 32'(o_block_lock), 32'd1);
      chk("t1_no_slips",   32'(o_slip_count), 32'd0);
      half();

      // 2: bad header on the 10th ev in HUNT, 4 ignored evs, then lock
      i_reset_n = 1'b0;
      beat(1'b0, 1'b0, 2'b00);
      i_reset_n = 1'b1;
      good_evs(9);
      ev1(2'b00);
      chk("t2_slip_pulse", 32'(o_slip), 32'd1);
      half();
      chk("t2_slip_one_cycle", 32'(o_slip), 32'd0);
      ignored_evs();
      chk("t2_not_locked", 32'(o_block_lock), 32'd0);
      good_evs(63);
      chk("t2_lock_before", 32'(o_block_lock), 32'd0);
      ev1(2'b01);
      chk("t2_lock_after", 32'(o_block_lock), 32'd1);
      chk("t2_count",      32'(o_slip_count), 32'd1);
      half();

      // 3: two windows with 15 bad headers each keep lock
      for (int i = 1; i <= 64; i++) begin
         ev1((i <= 15) ? 2'b00 : 2'b01);
         half();
      end
      chk("t3_win1_hold", 32'(o_block_lock), 32'd1);
      for (int i = 1; i <= 64; i++) begin
         ev1((i >= 50) ? 2'b11 : 2'b10);
         half();
      end
      chk("t3_win2_hold", 32'(o_block_lock), 32'd1);

      // 4: 16th bad header on ev #40 drops lock
      for (int i = 1; i <= 40; i++) begin
         ev1((i >= 25) ? 2'b00 : 2'b10);
         if (i == 39) chk("t4_hold_at_15", 32'(o_block_lock), 32'd1);
         if (i != 40) half();
      end
      chk("t4_lock_lost", 32'(o_block_lock), 32'd0);
      chk("t4_slip",      32'(o_slip),       32'd1);
      chk("t4_count",     32'(o_slip_count), 32'd2);
      half();
      ignored_evs();
      good_evs(64);
      chk("t4_relock", 32'(o_block_lock), 32'd1);

      // 5: 16th bad header on the 64th ev of the window
      for (int i = 1; i <= 64; i++) begin
         ev1((i >= 49) ? 2'b11 : 2'b01);
         if (i != 64) half();
      end
      chk("t5_lock_lost", 32'(o_block_lock), 32'd0);
      chk("t5_slip",      32'(o_slip),       32'd1);
      chk("t5_count",     32'(o_slip_count), 32'd3);
      half();

      // 6: init_done drop while locked, then async reset during SLIP_WAIT
      ignored_evs();
      good_evs(64);
      good_evs(10);
      ev1(2'b01);
      chk("t6_gate_open", 32'(o_rx_header_valid), 32'd1);
      i_init_done = 1'b0;
      ev1(2'b01);
      chk("t6_init_lock", 32'(o_block_lock),      32'd0);
      chk("t6_gate_shut", 32'(o_rx_header_valid), 32'd0);
      chk("t6_count_held", 32'(o_slip_count),     32'd3);
      i_init_done = 1'b1;
      half();
      good_evs(3);
      ev1(2'b11);
      chk("t6_slip", 32'(o_slip), 32'd1);
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("t6_arst_slip",  32'(o_slip),            32'd0);
      chk("t6_arst_lock",  32'(o_block_lock),      32'd0);
      chk("t6_arst_count", 32'(o_slip_count),      32'd0);
      chk("t6_arst_gate",  32'(o_rx_header_valid), 32'd0);
      @(posedge i_rxc);
      #1;
      i_reset_n = 1'b1;
      for (int i = 0; i < 8; i++) beat(1'b0, 1'b1, 2'b00);
      for (int i = 1; i <= 64; i++) begin
         ev1(2'b10);
         if (i == 63) chk("t6_gap_before", 32'(o_block_lock), 32'd0);
         beat(1'b0, 1'b1, 2'b11);
      end
      chk("t6_gap_lock",  32'(o_block_lock), 32'd1);
      chk("t6_gap_count", 32'(o_slip_count), 32'd0);
      beat(1'b0, 1'b0, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
